// File: rtl/ram_soc_pkg.sv
// Shared constants, FSM state type and byte-merge helper for the banked SoC RAM.
package ram_soc_pkg;

    localparam int DEF_DATA_W    = 64;
    localparam int DEF_ADDR_W    = 14;
    localparam int DEF_BANK_BITS = 1;

    // Widest word the merge helper handles; callers widen and truncate with casts.
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] stored,
        input logic [MAX_DATA_W-1:0] wdata,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = stored;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One bank: simple-dual-port RAM, one array per byte lane so byte writes map onto
// block RAM byte enables; registered read returns the pre-write contents.
module ram_bank #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 13
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data
);
    localparam int NUM_LANES = DATA_W / 8;
    localparam int DEPTH     = 2 ** ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) begin
                    mem[wr_addr] <= wr_data[8*gi +: 8];
                end
                if (rd_en) begin
                    q_reg <= mem[rd_addr];
                end
            end

            assign rd_data[8*gi +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/ram_soc_banked.sv
// Banked simple-dual-port RAM with byte enables, write-first same-address forwarding,
// selectable read latency (1 or 2) and a zero-fill pass after every reset.
module ram_soc_banked
    import ram_soc_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BANK_BITS = DEF_BANK_BITS,
    parameter int RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [ADDR_W-1:0]   wr_address,
    input  logic                write,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   rd_address,
    input  logic                read,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_valid,
    output logic                collision,
    output logic                init_done
);
    localparam int NUM_BANKS = 2 ** BANK_BITS;
    localparam int OFF_W     = ADDR_W - BANK_BITS;
    localparam int BE_W      = DATA_W / 8;

    state_t           state_reg;
    logic [OFF_W-1:0] init_ptr_reg;
    logic             init_done_reg;

    logic [BANK_BITS-1:0] wr_bank;
    logic [BANK_BITS-1:0] rd_bank;
    logic [OFF_W-1:0]     wr_off;
    logic [OFF_W-1:0]     rd_off;
    logic                 in_init;
    logic                 accept_wr;
    logic                 accept_rd;
    logic                 fwd_hit;

    logic [OFF_W-1:0]  bank_wr_addr;
    logic [DATA_W-1:0] bank_wr_data;
    logic [BE_W-1:0]   bank_wr_be;
    logic [DATA_W-1:0] bank_rd_data [NUM_BANKS];

    assign wr_bank   = wr_address[ADDR_W-1 -: BANK_BITS];
    assign rd_bank   = rd_address[ADDR_W-1 -: BANK_BITS];
    assign wr_off    = wr_address[OFF_W-1:0];
    assign rd_off    = rd_address[OFF_W-1:0];
    assign in_init   = (state_reg == INIT);
    assign accept_wr = (state_reg == RUN) && write;
    assign accept_rd = (state_reg == RUN) && read;
    assign fwd_hit   = accept_rd && accept_wr && (rd_address == wr_address);

    // During INIT every bank clears the same offset in parallel.
    assign bank_wr_addr = in_init ? init_ptr_reg : wr_off;
    assign bank_wr_data = in_init ? '0 : data_in;
    assign bank_wr_be   = in_init ? '1 : be;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic bank_wr_en;
            logic bank_rd_en;

            assign bank_wr_en = in_init || (accept_wr && (wr_bank == BANK_BITS'(gi)));
            assign bank_rd_en = accept_rd && (rd_bank == BANK_BITS'(gi));

            ram_bank #(
                .DATA_W (DATA_W),
                .ADDR_W (OFF_W)
            ) u_bank (
                .clk     (clk),
                .wr_en   (bank_wr_en),
                .wr_addr (bank_wr_addr),
                .wr_data (bank_wr_data),
                .wr_be   (bank_wr_be),
                .rd_en   (bank_rd_en),
                .rd_addr (rd_off),
                .rd_data (bank_rd_data[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= INIT;
            init_ptr_reg  <= '0;
            init_done_reg <= 1'b0;
        end else if (state_reg == INIT) begin
            init_ptr_reg <= init_ptr_reg + 1'b1;
            if (init_ptr_reg == '1) begin
                state_reg     <= RUN;
                init_done_reg <= 1'b1;
            end
        end
    end

    assign init_done = init_done_reg;

    // Stage 0: bank read in flight; capture the write side of a same-address hit
    // so it can be merged over the pre-write word the bank returns.
    logic                 rd_pend_reg;
    logic                 fwd_reg;
    logic [BANK_BITS-1:0] rd_bank_reg;
    logic [DATA_W-1:0]    fwd_data_reg;
    logic [BE_W-1:0]      fwd_be_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_reg  <= 1'b0;
            fwd_reg      <= 1'b0;
            rd_bank_reg  <= '0;
            fwd_data_reg <= '0;
            fwd_be_reg   <= '0;
        end else begin
            rd_pend_reg <= accept_rd;
            fwd_reg     <= fwd_hit;
            if (accept_rd) begin
                rd_bank_reg <= rd_bank;
            end
            if (fwd_hit) begin
                fwd_data_reg <= data_in;
                fwd_be_reg   <= be;
            end
        end
    end

    logic [DATA_W-1:0] stored_word;
    logic [DATA_W-1:0] read_word;

    assign stored_word = bank_rd_data[rd_bank_reg];
    assign read_word   = fwd_reg
        ? DATA_W'(merge_bytes(MAX_DATA_W'(stored_word), MAX_DATA_W'(fwd_data_reg),
                              MAX_BE_W'(fwd_be_reg)))
        : stored_word;

    // Stage 1: first output register; data holds its value between reads.
    logic [DATA_W-1:0] s1_data_reg;
    logic              s1_valid_reg;
    logic              s1_coll_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_reg  <= '0;
            s1_valid_reg <= 1'b0;
            s1_coll_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= rd_pend_reg;
            s1_coll_reg  <= rd_pend_reg && fwd_reg;
            if (rd_pend_reg) begin
                s1_data_reg <= read_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data_reg;
            logic              s2_valid_reg;
            logic              s2_coll_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_data_reg  <= '0;
                    s2_valid_reg <= 1'b0;
                    s2_coll_reg  <= 1'b0;
                end else begin
                    s2_valid_reg <= s1_valid_reg;
                    s2_coll_reg  <= s1_coll_reg;
                    if (s1_valid_reg) begin
                        s2_data_reg <= s1_data_reg;
                    end
                end
            end

            assign data_out   = s2_data_reg;
            assign data_valid = s2_valid_reg;
            assign collision  = s2_coll_reg;
        end else begin : g_lat1
            assign data_out   = s1_data_reg;
            assign data_valid = s1_valid_reg;
            assign collision  = s1_coll_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ram_soc_banked.sv
// Scoreboard bench: three instances (6-bit init check, 14-bit at RD_LAT 1 and 2);
// stimulus pushes expected responses, per-instance monitors pop and compare.
module tb_ram_soc_banked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [63:0] a_din;
    logic [5:0]  a_wa;
    logic [5:0]  a_ra;
    logic        a_w;
    logic        a_r;
    logic [7:0]  a_be;
    logic [63:0] a_dout;
    logic        a_valid;
    logic        a_coll;
    logic        a_done;

    logic [63:0] s_din;
    logic [13:0] s_wa;
    logic [13:0] s_ra;
    logic        s_w;
    logic        s_r;
    logic [7:0]  s_be;
    logic [63:0] b_dout;
    logic        b_valid;
    logic        b_coll;
    logic        b_done;
    logic [63:0] c_dout;
    logic        c_valid;
    logic        c_coll;
    logic        c_done;

    typedef struct {
        logic [63:0] data;
        logic        coll;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    ram_soc_banked #(.DATA_W(64), .ADDR_W(6), .BANK_BITS(1), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(a_din), .wr_address(a_wa), .write(a_w),
        .be(a_be), .rd_address(a_ra), .read(a_r), .data_out(a_dout),
        .data_valid(a_valid), .collision(a_coll), .init_done(a_done)
    );

    ram_soc_banked #(.DATA_W(64), .ADDR_W(14), .BANK_BITS(1), .RD_LAT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(s_din), .wr_address(s_wa), .write(s_w),
        .be(s_be), .rd_address(s_ra), .read(s_r), .data_out(b_dout),
        .data_valid(b_valid), .collision(b_coll), .init_done(b_done)
    );

    ram_soc_banked #(.DATA_W(64), .ADDR_W(14), .BANK_BITS(1), .RD_LAT(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .data_in(s_din), .wr_address(s_wa), .write(s_w),
        .be(s_be), .rd_address(s_ra), .read(s_r), .data_out(c_dout),
        .data_valid(c_valid), .collision(c_coll), .init_done(c_done)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void check_rsp(input string tag, input exp_t e, input logic [63:0] d,
                                      input logic c);
        chk({tag, "_data"}, d, e.data);
        chk({tag, "_collision"}, 64'(c), 64'(e.coll));
        chk({tag, "_valid_cycle"}, 64'(cyc), 64'(e.due));
        $display("%s rsp cyc=%0d data=%h collision=%0b", tag, cyc, d, c);
    endfunction

    always @(negedge clk) begin
        if (a_valid) begin
            if (q_a.size() == 0) chk("a_unexpected_valid", 64'(a_valid), 64'd0);
            else check_rsp("a", q_a.pop_front(), a_dout, a_coll);
        end
        if (b_valid) begin
            if (q_b.size() == 0) chk("b_unexpected_valid", 64'(b_valid), 64'd0);
            else check_rsp("b", q_b.pop_front(), b_dout, b_coll);
        end
        if (c_valid) begin
            if (q_c.size() == 0) chk("c_unexpected_valid", 64'(c_valid), 64'd0);
            else check_rsp("c", q_c.pop_front(), c_dout, c_coll);
        end
    end

    // One cycle of stimulus on the shared 14-bit instances; a read queues its response.
    task automatic op(input logic w, input logic [13:0] wa, input logic [63:0] wd,
                      input logic [7:0] wbe, input logic r, input logic [13:0] ra,
                      input logic [63:0] exp_d, input logic exp_c);
        exp_t e;
        @(negedge clk);
        s_w = w; s_wa = wa; s_din = wd; s_be = wbe;
        s_r = r; s_ra = ra;
        if (r) begin
            e.data = exp_d;
            e.coll = exp_c;
            e.due  = cyc + 2;
            q_b.push_back(e);
            e.due  = cyc + 3;
            q_c.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_w = 1'b0;
            s_r = 1'b0;
        end
    endtask

    task automatic a_read(input logic [5:0] addr);
        exp_t e;
        @(negedge clk);
        a_w = 1'b0; a_r = 1'b1; a_ra = addr;
        e.data = 64'd0;
        e.coll = 1'b0;
        e.due  = cyc + 2;
        q_a.push_back(e);
    endtask

    task automatic wait_bc_init(input int limit);
        int n = 0;
        while (b_done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("b_init_done_timeout", 64'(b_done), 64'd1);
        chk("c_init_done", 64'(c_done), 64'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_w = 1'b0; a_r = 1'b0; a_din = '0; a_wa = '0; a_ra = '0; a_be = '0;
        s_w = 1'b0; s_r = 1'b0; s_din = '0; s_wa = '0; s_ra = '0; s_be = '0;
        repeat (3) @(negedge clk);

        chk("rst_b_data_out", b_dout, 64'd0);
        chk("rst_b_data_valid", 64'(b_valid), 64'd0);
        chk("rst_b_collision", 64'(b_coll), 64'd0);
        chk("rst_b_init_done", 64'(b_done), 64'd0);
        chk("rst_c_data_out", c_dout, 64'd0);
        chk("rst_a_init_done", 64'(a_done), 64'd0);

        // 6-bit instance: init length, and a write+read issued mid-INIT are ignored.
        rst_n = 1'b1;
        begin
            int n = 0;
            bit seen = 1'b0;
            while (n < 100 && !seen) begin
                @(negedge clk);
                n++;
                a_w = (n == 3); a_wa = 6'h05; a_din = '1; a_be = 8'hFF;
                a_r = (n == 3); a_ra = 6'h05;
                if (a_done) seen = 1'b1;
            end
            chk("a_init_cycles", 64'(n), 64'd32);
        end
        a_read(6'h00);
        a_read(6'h1F);
        a_read(6'h3F);
        a_read(6'h05);
        @(negedge clk);
        a_r = 1'b0;

        wait_bc_init(9000);

        // Bank 1 of a 14-bit address starts at 14'h2000 (bit 13 selects the bank).
        op(1, 14'h0001, 64'h1111_2222_3333_4444, 8'hFF, 0, 14'h0, 64'h0, 0);
        op(1, 14'h2002, 64'h5555_6666_7777_8888, 8'hFF, 0, 14'h0, 64'h0, 0);
        op(0, 14'h0, 64'h0, 8'h00, 1, 14'h0001, 64'h1111_2222_3333_4444, 0);
        op(0, 14'h0, 64'h0, 8'h00, 1, 14'h2002, 64'h5555_6666_7777_8888, 0);
        op(0, 14'h0, 64'h0, 8'h00, 1, 14'h2001, 64'h0, 0);
        op(0, 14'h0, 64'h0, 8'h00, 1, 14'h0002, 64'h0, 0);
        op(0, 14'h0, 64'h0, 8'h00, 1, 14'h3FFF, 64'h0, 0);
        op(1, 14'h0010, 64'h1111_2222_3333_4444, 8'hFF, 0, 14'h0, 64'h0, 0);
        op(1, 14'h0010, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 0, 14'h0, 64'h0, 0);
        op(0, 14'h0, 64'h0, 8'h00, 1, 14'h0010, 64'h1111_2222_CCCC_DDDD, 0);
        op(1, 14'h0020, 64'hDEAD_BEEF_0000_FFFF, 8'hF0, 1, 14'h0020, 64'hDEAD_BEEF_0000_0000, 1);
        op(1, 14'h0020, 64'hDEAD_BEEF_0000_FFFF, 8'hF0, 1, 14'h0021, 64'h0, 0);
        op(1, 14'h0010, 64'h9999_9999_9999_9999, 8'h81, 1, 14'h0010, 64'h9911_2222_CCCC_DD99, 1);
        op(0, 14'h0, 64'h0, 8'h00, 1, 14'h0010, 64'h9911_2222_CCCC_DD99, 0);
        op(1, 14'h2020, 64'h7777_7777_7777_7777, 8'hFF, 1, 14'h0020, 64'hDEAD_BEEF_0000_0000, 0);
        op(1, 14'h0001, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 14'h0, 64'h0, 0);
        idle(1);

        // Four back-to-back reads must come back on four consecutive cycles.
        op(0, 14'h0, 64'h0, 8'h00, 1, 14'h0001, 64'h1111_2222_3333_4444, 0);
        op(0, 14'h0, 64'h0, 8'h00, 1, 14'h2002, 64'h5555_6666_7777_8888, 0);
        op(0, 14'h0, 64'h0, 8'h00, 1, 14'h0010, 64'h9911_2222_CCCC_DD99, 0);
        op(0, 14'h0, 64'h0, 8'h00, 1, 14'h0020, 64'hDEAD_BEEF_0000_0000, 0);
        idle(6);

        chk("b_hold_data_out", b_dout, 64'hDEAD_BEEF_0000_0000);
        chk("c_hold_data_out", c_dout, 64'hDEAD_BEEF_0000_0000);
        chk("b_hold_data_valid", 64'(b_valid), 64'd0);

        // Reset one cycle after a read strobe: that read must never complete.
        @(negedge clk);
        s_r = 1'b1; s_ra = 14'h0001; s_w = 1'b0;
        @(negedge clk);
        s_r = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_b_init_done", 64'(b_done), 64'd0);
        chk("midrst_c_init_done", 64'(c_done), 64'd0);
        chk("midrst_a_init_done", 64'(a_done), 64'd0);
        chk("midrst_b_data_out", b_dout, 64'd0);
        chk("midrst_c_data_out", c_dout, 64'd0);
        rst_n = 1'b1;
        wait_bc_init(9000);
        op(0, 14'h0, 64'h0, 8'h00, 1, 14'h0001, 64'h0, 0);
        op(0, 14'h0, 64'h0, 8'h00, 1, 14'h2002, 64'h0, 0);
        idle(6);

        chk("a_pending_responses", 64'(q_a.size()), 64'd0);
        chk("b_pending_responses", 64'(q_b.size()), 64'd0);
        chk("c_pending_responses", 64'(q_c.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
